// File: rtl/par2serial_sym_gen.sv
// par2serial_sym_gen: bit-rate parallel-to-serial lane generator.
// Sends an IDLE alignment preamble, then payload words or filler symbols.
module par2serial_sym_gen #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  SYM_IDLE   = 'hBC,
    parameter logic [WIDTH-1:0]  SYM_ACTIVE = 'h7C,
    parameter int unsigned       SYNC_WORDS = 4,
    parameter bit                LSB_FIRST  = 1'b0
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             active,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             data_out,
    output logic             bit_sync,
    output logic             word_taken,
    output logic             sync_done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = $clog2(SYNC_WORDS + 1);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SYNC_WORDS - 1);

    typedef enum logic {
        INIT,
        OPER
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] shreg;

    logic [WIDTH-1:0] word;
    logic             take;
    logic             boundary;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] rest;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        word = SYM_IDLE;
        take = 1'b0;
        if (state == OPER && active) begin
            if (valid_in) begin
                word = data_in;
                take = 1'b1;
            end else begin
                word = SYM_ACTIVE;
            end
        end
    end

    assign boundary  = (cnt == LAST);
    assign first_bit = LSB_FIRST ? word[0] : word[WIDTH-1];
    assign rest      = LSB_FIRST ? (word >> 1) : (word << 1);
    assign next_bit  = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    assign shifted   = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

    // cnt resets to LAST so the first edge after release starts a word
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            cnt        <= LAST;
            pre_cnt    <= '0;
            shreg      <= '0;
            data_out   <= 1'b0;
            bit_sync   <= 1'b0;
            word_taken <= 1'b0;
            sync_done  <= 1'b0;
        end else if (boundary) begin
            data_out   <= first_bit;
            shreg      <= rest;
            cnt        <= '0;
            bit_sync   <= 1'b1;
            word_taken <= take;
            if (state == INIT) begin
                pre_cnt <= pre_cnt + PW'(1);
                if (pre_cnt == PRE_LAST) begin
                    state     <= OPER;
                    sync_done <= 1'b1;
                end
            end
        end else begin
            data_out   <= next_bit;
            shreg      <= shifted;
            cnt        <= cnt + CW'(1);
            bit_sync   <= 1'b0;
            word_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_par2serial_sym_gen.sv
// tb_par2serial_sym_gen: word-level model check of the serial generator,
// plus captured-word literals for MSB, LSB-first and 10-bit variants.
module tb_par2serial_sym_gen;

    logic       clk;
    logic       rst_n;
    logic       active;
    logic       valid_in;
    logic [7:0] data_in;

    logic do0, bs0, wt0, sd0;
    logic do1, bs1, wt1, sd1;
    logic do2, bs2, wt2, sd2;

    logic [2:0] do_a, bs_a, wt_a;
    assign do_a = {do2, do1, do0};
    assign bs_a = {bs2, bs1, bs0};
    assign wt_a = {wt2, wt1, wt0};

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [9:0] words0[$];
    logic [9:0] words1[$];
    logic [9:0] words2[$];

    par2serial_sym_gen u0 (
        .clk_32f   (clk),
        .reset     (rst_n),
        .active    (active),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (do0),
        .bit_sync  (bs0),
        .word_taken(wt0),
        .sync_done (sd0)
    );

    par2serial_sym_gen #(.LSB_FIRST(1'b1)) u1 (
        .clk_32f   (clk),
        .reset     (rst_n),
        .active    (1'b1),
        .data_in   (8'h01),
        .valid_in  (1'b1),
        .data_out  (do1),
        .bit_sync  (bs1),
        .word_taken(wt1),
        .sync_done (sd1)
    );

    par2serial_sym_gen #(
        .WIDTH     (10),
        .SYM_IDLE  (10'h17C),
        .SYM_ACTIVE(10'h283)
    ) u2 (
        .clk_32f   (clk),
        .reset     (rst_n),
        .active    (1'b1),
        .data_in   (10'h000),
        .valid_in  (1'b0),
        .data_out  (do2),
        .bit_sync  (bs2),
        .word_taken(wt2),
        .sync_done (sd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Word-level model of u0: word k starts at edge 8k after reset release.
    function automatic logic [8:0] pick(input int unsigned k, input logic a,
                                        input logic v, input logic [7:0] d);
        if (k < 4)  return {1'b0, 8'hBC};
        if (!a)     return {1'b0, 8'hBC};
        if (v)      return {1'b1, d};
        return {1'b0, 8'h7C};
    endfunction

    int unsigned t   = 0;
    logic [7:0]  cur = '0;
    logic        e_do = 1'b0, e_bs = 1'b0, e_wt = 1'b0, e_sd = 1'b0;
    logic [8:0]  sel;
    assign sel = pick(t / 8, active, valid_in, data_in);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t    <= 0;
            cur  <= '0;
            e_do <= 1'b0;
            e_bs <= 1'b0;
            e_wt <= 1'b0;
            e_sd <= 1'b0;
        end else begin
            t <= t + 1;
            if (t % 8 == 0) begin
                cur  <= sel[7:0];
                e_do <= sel[7];
                e_bs <= 1'b1;
                e_wt <= sel[8];
                e_sd <= (t / 8 >= 3);
            end else begin
                e_do <= cur[7 - (t % 8)];
                e_bs <= 1'b0;
                e_wt <= 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("data_out", do0, e_do);
        chk("bit_sync", bs0, e_bs);
        chk("word_taken", wt0, e_wt);
        chk("sync_done", sd0, e_sd);
    end

    task automatic push_word(input int id, input logic [9:0] w);
        case (id)
            0:       words0.push_back(w);
            1:       words1.push_back(w);
            default: words2.push_back(w);
        endcase
    endtask

    // Rebuild words first-bit-first; discard partial words on reset.
    task automatic assemble(input int id, input int w);
        logic [9:0] acc;
        int n, nw;
        acc = '0;
        n   = 0;
        nw  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n  = 0;
                nw = 0;
            end else if (bs_a[id]) begin
                if (n != 0) chk($sformatf("u%0d_period", id), n, w);
                if (id == 1) chk("u1_taken", wt_a[1], nw >= 4);
                if (id == 2) chk("u2_taken", wt_a[2], 1'b0);
                acc = {9'b0, do_a[id]};
                n   = 1;
                nw++;
            end else if (n != 0) begin
                acc = {acc[8:0], do_a[id]};
                n++;
                if (n == w) push_word(id, acc);
            end
        end
    endtask

    initial fork
        assemble(0, 8);
        assemble(1, 8);
        assemble(2, 10);
    join_none

    task automatic next_word(input int dly);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bs0 && guard < 40);
        if (!bs0) begin
            total_cnt++;
            $display("FAIL word_wait: no bit_sync within %0d cycles", guard);
        end
        repeat (dly) @(negedge clk);
    endtask

    // Vector i is applied after word i starts and governs word i+1.
    int         vdly[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
    logic       va[13]   = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
    logic       vv[13]   = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1};
    logic [7:0] vd[13]   = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h00,
                             8'h00, 8'h5A, 8'h5A, 8'hBC, 8'h00, 8'h00,
                             8'hC3};

    logic [9:0] exp0[19] = '{10'hBC, 10'hBC, 10'hBC, 10'hBC, 10'hA5,
                             10'h3C, 10'h7C, 10'h7C, 10'hBC, 10'hBC,
                             10'hBC, 10'h7C, 10'hBC, 10'hBC, 10'hBC,
                             10'hBC, 10'hBC, 10'h96, 10'h7C};
    logic [9:0] exp1[6]  = '{10'h3D, 10'h3D, 10'h3D, 10'h3D,
                             10'h80, 10'h80};
    logic [9:0] exp2[6]  = '{10'h17C, 10'h17C, 10'h17C, 10'h17C,
                             10'h283, 10'h283};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        active   = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hA5;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            next_word(vdly[i]);
            active   = va[i];
            valid_in = vv[i];
            data_in  = vd[i];
        end

        next_word(5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_out", do0, 1'b0);
        chk("rst_bit_sync", bs0, 1'b0);
        chk("rst_word_taken", wt0, 1'b0);
        chk("rst_sync_done", sd0, 1'b0);
        active   = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'h96;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (5) next_word(0);
        valid_in = 1'b0;
        repeat (3) next_word(0);

        chk("u0_word_count", words0.size() >= 19, 1'b1);
        for (int i = 0; i < 19; i++)
            if (i < words0.size())
                chk($sformatf("u0_word%0d", i), words0[i], exp0[i]);
        chk("u1_word_count", words1.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            if (i < words1.size())
                chk($sformatf("u1_word%0d", i), words1[i], exp1[i]);
        chk("u2_word_count", words2.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            if (i < words2.size())
                chk($sformatf("u2_word%0d", i), words2[i], exp2[i]);
        chk("u1_sync_done", sd1, 1'b1);
        chk("u2_sync_done", sd2, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
